// File: rtl/pipelined_segment_adder.sv
// Segmented add/subtract pipeline: one SEG_WIDTH slice per stage, carry registered
// between stages, valid/ready handshake with a single global advance.

module seg_add #(
  parameter int SW = 32
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          carry
);
  assign {carry, sum} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
endmodule

module pipelined_segment_adder #(
  parameter int WIDTH     = 64,
  parameter int SEG_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c0,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output1,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int SW   = SEG_WIDTH;
  localparam int NSEG = WIDTH / SEG_WIDTH;

  logic             adv;
  logic [NSEG-1:0]  vld_pipe;
  logic [WIDTH-1:0] b_ent;
  logic             c_ent;
  logic [WIDTH-1:0] res_nx;
  logic             cout_nx;
  logic             ovf_nx;
  logic             last_vld;

  // Whole pipe moves as one; only a stalled valid result can freeze it.
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[NSEG-1];
  assign b_ent     = sub ? ~B : B;
  assign c_ent     = sub | c0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[0] <= in_valid;
      for (int k = 1; k < NSEG; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    // Remaining operand bits still to be added, starting at segment k.
    localparam int REM = WIDTH - k*SW;

    logic [REM-1:0]        src_a;
    logic [REM-1:0]        src_b;
    logic                  src_c;
    logic                  src_vld;
    logic [SW-1:0]         seg_s;
    logic                  seg_c;
    logic [(k+1)*SW-1:0]   done;

    if (k == 0) begin : g_entry
      assign src_a   = A;
      assign src_b   = b_ent;
      assign src_c   = c_ent;
      assign src_vld = in_valid;
      assign done    = seg_s;
    end else begin : g_chain
      assign src_a   = g_stage[k-1].g_mid.a_q;
      assign src_b   = g_stage[k-1].g_mid.b_q;
      assign src_c   = g_stage[k-1].g_mid.c_q;
      assign src_vld = vld_pipe[k-1];
      assign done    = {seg_s, g_stage[k-1].g_mid.sum_q};
    end

    seg_add #(.SW(SW)) u_add (
      .a     (src_a[SW-1:0]),
      .b     (src_b[SW-1:0]),
      .cin   (src_c),
      .sum   (seg_s),
      .carry (seg_c)
    );

    if (k < NSEG-1) begin : g_mid
      logic [REM-SW-1:0]   a_q;
      logic [REM-SW-1:0]   b_q;
      logic [(k+1)*SW-1:0] sum_q;
      logic                c_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          sum_q <= '0;
          c_q   <= 1'b0;
        end else if (adv & src_vld) begin
          a_q   <= src_a[REM-1:SW];
          b_q   <= src_b[REM-1:SW];
          sum_q <= done;
          c_q   <= seg_c;
        end
      end
    end else begin : g_last
      assign res_nx   = done;
      assign cout_nx  = seg_c;
      assign last_vld = src_vld;
      // src_b already carries the subtract inversion, so this is the b' sign.
      assign ovf_nx   = (src_a[SW-1] == src_b[SW-1]) & (seg_s[SW-1] != src_a[SW-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      output1  <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (adv & last_vld) begin
      output1  <= res_nx;
      cout     <= cout_nx;
      overflow <= ovf_nx;
      zero     <= ~|res_nx;
    end
  end

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Directed bench: two instances (32-bit and 16-bit segments) sharing operands and reset.

module tb_pipelined_segment_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [63:0]      A, B;
  logic             c0, sub;
  logic [1:0]       iv, ordy, ir, ov, co, of, zr;
  logic [1:0][63:0] res;
  int               n_chk = 0;
  int               n_err = 0;

  pipelined_segment_adder #(.WIDTH(64), .SEG_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .A(A), .B(B),
    .c0(c0), .sub(sub), .out_valid(ov[0]), .out_ready(ordy[0]),
    .output1(res[0]), .cout(co[0]), .overflow(of[0]), .zero(zr[0])
  );

  pipelined_segment_adder #(.WIDTH(64), .SEG_WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .A(A), .B(B),
    .c0(c0), .sub(sub), .out_valid(ov[1]), .out_ready(ordy[1]),
    .output1(res[1]), .cout(co[1]), .overflow(of[1]), .zero(zr[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one operation to dut d (called at a negedge) and check latency and result.
  task automatic run_op(input int d, input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic c, input logic s, input logic [63:0] er,
                        input logic ec, input logic eo, input logic ez);
    int lat;
    lat = (d == 0) ? 2 : 4;
    A = a; B = b; c0 = c; sub = s;
    iv[d] = 1'b1; ordy[d] = 1'b1;
    step();
    iv[d] = 1'b0;
    for (int i = 1; i < lat; i++) begin
      chk({tag, "_early"}, 64'(ov[d]), 64'd0);
      step();
    end
    chk({tag, "_valid"}, 64'(ov[d]), 64'd1);
    chk({tag, "_res"},   res[d],     er);
    chk({tag, "_cout"},  64'(co[d]), 64'(ec));
    chk({tag, "_ovf"},   64'(of[d]), 64'(eo));
    chk({tag, "_zero"},  64'(zr[d]), 64'(ez));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          sent, recv, cyc;
    logic        held;
    logic [63:0] held_val;

    rst = 1'b1; iv = '0; ordy = 2'b11; A = '0; B = '0; c0 = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ov",    64'(ov[d]), 64'd0);
      chk("rst_res",   res[d],     64'd0);
      chk("rst_cout",  64'(co[d]), 64'd0);
      chk("rst_ovf",   64'(of[d]), 64'd0);
      chk("rst_zero",  64'(zr[d]), 64'd0);
      chk("rst_ready", 64'(ir[d]), 64'd1);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_ov32", 64'(ov[0]), 64'd0);
      chk("idle_ov16", 64'(ov[1]), 64'd0);
    end

    for (int d = 0; d < 2; d++) begin
      run_op(d, "carry", 64'h00000000_FFFFFFFF, 64'd1, 1'b0, 1'b0, 64'h00000001_00000000, 1'b0, 1'b0, 1'b0);
      run_op(d, "wrap",  64'hFFFFFFFF_FFFFFFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
      run_op(d, "sovf",  64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b0, 64'h80000000_00000000, 1'b0, 1'b1, 1'b0);
      run_op(d, "sub_eq", 64'd7, 64'd7, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1);
      run_op(d, "sub_neg", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b0, 1'b0);
    end
    sub = 1'b0; c0 = 1'b0;
    step();

    // Backpressure stream on the 32-bit-segment instance: out_ready cycles 1,0,0,1.
    sent = 0; recv = 0; cyc = 0; held = 1'b0; held_val = '0;
    while (recv < 6 && cyc < 200) begin
      ordy[0] = (cyc % 4 == 0) || (cyc % 4 == 3);
      iv[0]   = (sent < 6);
      A = 64'(sent); B = 64'(sent);
      #1;
      chk("bp_ready", 64'(ir[0]), 64'(!(ov[0] && !ordy[0])));
      if (held) chk("bp_hold", res[0], held_val);
      if (ov[0] && ordy[0]) begin
        chk("bp_res", res[0], 64'(2 * recv));
        recv++;
      end
      held     = ov[0] && !ordy[0];
      held_val = res[0];
      if (iv[0] && ir[0]) sent++;
      step();
      cyc++;
    end
    chk("bp_count", 64'(recv), 64'd6);
    iv[0] = 1'b0; ordy[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_nodup", 64'(ov[0]), 64'd0);
      step();
    end

    // Two tokens in flight in the 16-bit-segment instance, then reset.
    A = 64'd100; B = 64'd1; iv[1] = 1'b1; ordy[1] = 1'b1;
    step();
    A = 64'd200;
    step();
    iv[1] = 1'b0;
    rst = 1'b1;
    chk("mid_inflight", 64'(ov[1]), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_ov",  64'(ov[1]), 64'd0);
    chk("mid_rst_res", res[1],     64'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_dropped", 64'(ov[1]), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
